// File: rtl/fft_bfly_addr_gen.sv
// Butterfly index / twiddle address sequencer for an in-place radix-2 DIT FFT.
module fft_bfly_addr_gen #(
  parameter int unsigned LOG2N     = 3,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              bfly_valid,
  input  logic              bfly_ready,
  output logic [LOG2N-1:0]  idx_a,
  output logic [LOG2N-1:0]  idx_b,
  output logic [LOG2N-1:0]  bfly_stage,
  output logic              busy,
  output logic              done
);

  localparam int unsigned HALF  = 1 << (LOG2N - 1);
  localparam int unsigned GAP_W = (STAGE_GAP > 0) ? $clog2(STAGE_GAP + 1) : 1;
  localparam logic [LOG2N-1:0] LAST_J = LOG2N'(HALF - 1);
  localparam logic [LOG2N-1:0] LAST_S = LOG2N'(LOG2N - 1);

  if (LOG2N * HALF > (1 << ADDR_W)) begin : g_addr_too_narrow
    $error("fft_bfly_addr_gen: twiddle table does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} state_t;

  state_t             r_state;
  logic [LOG2N-1:0]   r_s;
  logic [LOG2N-1:0]   r_j;
  logic [GAP_W-1:0]   r_gap;
  logic [ADDR_W-1:0]  r_held_addr;
  logic               r_valid;
  logic [LOG2N-1:0]   r_idx_a;
  logic [LOG2N-1:0]   r_idx_b;
  logic [LOG2N-1:0]   r_stage;
  logic               r_done;

  logic               w_adv;
  logic [LOG2N-1:0]   w_span;
  logic [LOG2N-1:0]   w_pos;
  logic [LOG2N-1:0]   w_a;
  logic [LOG2N-1:0]   w_b;
  logic [ADDR_W-1:0]  w_addr;

  // grp*2*span is (j>>s)<<(s+1); pos fills the low s bits
  assign w_span = LOG2N'(1) << r_s;
  assign w_pos  = r_j & (w_span - LOG2N'(1));
  assign w_a    = ((r_j >> r_s) << (r_s + LOG2N'(1))) | w_pos;
  assign w_b    = w_a + w_span;
  assign w_addr = ADDR_W'(r_s) * ADDR_W'(HALF) + ADDR_W'(r_j);

  assign w_adv   = (r_state == RUN) && (!r_valid || bfly_ready);
  // While stalled the ROM keeps re-reading the presented item's address
  assign tw_addr = w_adv ? w_addr : r_held_addr;

  assign bfly_valid = r_valid;
  assign idx_a      = r_idx_a;
  assign idx_b      = r_idx_b;
  assign bfly_stage = r_stage;
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_j         <= '0;
      r_gap       <= '0;
      r_held_addr <= '0;
      r_valid     <= 1'b0;
      r_idx_a     <= '0;
      r_idx_b     <= '0;
      r_stage     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_s     <= '0;
        r_j     <= '0;
        r_gap   <= '0;
      end else begin
        if (w_adv) begin
          r_idx_a     <= w_a;
          r_idx_b     <= w_b;
          r_stage     <= r_s;
          r_valid     <= 1'b1;
          r_held_addr <= w_addr;
        end else if (r_valid && bfly_ready) begin
          r_valid <= 1'b0;
        end

        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= RUN;
              r_s     <= '0;
              r_j     <= '0;
            end
          end
          RUN: begin
            if (w_adv) begin
              if (r_j == LAST_J) begin
                r_j <= '0;
                if (r_s == LAST_S) begin
                  r_state <= FLUSH;
                end else begin
                  r_s <= r_s + LOG2N'(1);
                  if (STAGE_GAP == 0) begin
                    r_state <= RUN;
                  end else begin
                    r_state <= GAP;
                    r_gap   <= GAP_W'(STAGE_GAP);
                  end
                end
              end else begin
                r_j <= r_j + LOG2N'(1);
              end
            end
          end
          // STAGE_GAP GAP cycles plus the RUN issue cycle give STAGE_GAP empty slots
          GAP: begin
            if (r_gap <= GAP_W'(1)) begin
              r_state <= RUN;
              r_gap   <= '0;
            end else begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
          FLUSH: begin
            if (r_valid && bfly_ready) begin
              r_state <= IDLE;
              r_s     <= '0;
              r_j     <= '0;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// Bench for fft_bfly_addr_gen: N=8 build with STAGE_GAP=4 plus a STAGE_GAP=0 build.
module tb_fft_bfly_addr_gen;

  localparam int LOG2N     = 3;
  localparam int ADDR_W    = 5;
  localparam int STAGE_GAP = 4;
  localparam int HALF      = 4;
  localparam int NB        = 12;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort, bfly_ready;
  logic [ADDR_W-1:0] tw_addr;
  logic              bfly_valid, busy, done;
  logic [LOG2N-1:0]  idx_a, idx_b, bfly_stage;

  logic              z_start, z_abort, z_ready;
  logic [ADDR_W-1:0] z_tw_addr;
  logic              z_valid, z_busy, z_done;
  logic [LOG2N-1:0]  z_idx_a, z_idx_b, z_stage;

  fft_bfly_addr_gen #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .STAGE_GAP(STAGE_GAP)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tw_addr(tw_addr),
    .bfly_valid(bfly_valid), .bfly_ready(bfly_ready), .idx_a(idx_a), .idx_b(idx_b),
    .bfly_stage(bfly_stage), .busy(busy), .done(done)
  );

  fft_bfly_addr_gen #(.LOG2N(LOG2N), .ADDR_W(ADDR_W), .STAGE_GAP(0)) u_dut_gap0 (
    .clk(clk), .rst_n(rst_n), .start(z_start), .abort(z_abort), .tw_addr(z_tw_addr),
    .bfly_valid(z_valid), .bfly_ready(z_ready), .idx_a(z_idx_a), .idx_b(z_idx_b),
    .bfly_stage(z_stage), .busy(z_busy), .done(z_done)
  );

  // Twiddle ROM stand-in: 1-cycle registered read
  logic [15:0] rom [0:31];
  logic [15:0] rom_q, z_rom_q;
  always @(posedge clk) begin
    rom_q   <= rom[tw_addr];
    z_rom_q <= rom[z_tw_addr];
  end

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] s;
    logic [4:0] addr;
  } item_t;

  item_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void build_exp();
    exp_q.delete();
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < HALF; j++) begin
        int span;
        int a;
        item_t it;
        span    = 1 << s;
        a       = (j / span) * 2 * span + (j % span);
        it.a    = 3'(a);
        it.b    = 3'(a + span);
        it.s    = 3'(s);
        it.addr = 5'(s * HALF + j);
        exp_q.push_back(it);
      end
    end
  endfunction

  task automatic score_run(input string tag, input int ready_pct, input int stall_idx,
                           input int poke_cyc, input bit check_gaps);
    int n_acc, n_done, stall_left, post;
    int acc_cyc[$];
    bit stalling, done_seen;
    item_t it;
    build_exp();
    n_acc = 0; n_done = 0; stall_left = 5; post = 0; done_seen = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 2000 && post < 4; cyc++) begin
      start = (cyc == poke_cyc);
      if (stall_idx >= 0 && bfly_valid && n_acc == stall_idx && stall_left > 0) begin
        bfly_ready = 1'b0;
        stall_left--;
        stalling = 1'b1;
      end else begin
        bfly_ready = ($urandom_range(0, 99) < ready_pct);
        stalling = 1'b0;
      end
      @(negedge clk);
      if (bfly_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL %s extra_item: got idx_a=%0d idx_b=%0d with none expected", tag, idx_a, idx_b);
        end else begin
          it = exp_q[0];
          n_cmp++;
          if (rom_q !== rom[it.addr]) begin
            n_err++;
            $display("FAIL %s rom_data: got %h expected %h (addr %0d)", tag, rom_q, rom[it.addr], it.addr);
          end
          if (stalling) begin
            n_cmp++;
            if ({idx_a, idx_b, tw_addr} !== {it.a, it.b, it.addr}) begin
              n_err++;
              $display("FAIL %s stall_hold: got a=%0d b=%0d tw=%0d expected a=%0d b=%0d tw=%0d",
                       tag, idx_a, idx_b, tw_addr, it.a, it.b, it.addr);
            end
          end
          if (bfly_ready) begin
            void'(exp_q.pop_front());
            acc_cyc.push_back(cyc);
            n_acc++;
            n_cmp++;
            if ({idx_a, idx_b, bfly_stage} !== {it.a, it.b, it.s}) begin
              n_err++;
              $display("FAIL %s item%0d: got a=%0d b=%0d s=%0d expected a=%0d b=%0d s=%0d",
                       tag, n_acc - 1, idx_a, idx_b, bfly_stage, it.a, it.b, it.s);
            end
          end
        end
      end
      if (done) begin
        n_done++;
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s done_timing: got remaining=%0d busy=%b expected remaining=0 busy=0",
                   tag, exp_q.size(), busy);
        end
        done_seen = 1'b1;
      end
      if (done_seen) post++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (n_acc != NB) begin
      n_err++;
      $display("FAIL %s accept_count: got %0d expected %0d", tag, n_acc, NB);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d expected 1", tag, n_done);
    end
    if (stall_idx >= 0) begin
      n_cmp++;
      if (stall_left != 0) begin
        n_err++;
        $display("FAIL %s stall_reached: got %0d stall cycles left expected 0", tag, stall_left);
      end
    end
    if (check_gaps) begin
      for (int k = 1; k < acc_cyc.size(); k++) begin
        int want;
        want = (k % HALF == 0) ? STAGE_GAP + 1 : 1;
        n_cmp++;
        if (acc_cyc[k] - acc_cyc[k-1] != want) begin
          n_err++;
          $display("FAIL %s spacing%0d: got %0d cycles expected %0d", tag, k, acc_cyc[k] - acc_cyc[k-1], want);
        end
      end
    end
  endtask

  task automatic test_reset();
    int n_acc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tw_addr, bfly_valid, idx_a, idx_b, bfly_stage, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got tw=%0d v=%b a=%0d b=%0d s=%0d busy=%b done=%b expected all 0",
               tw_addr, bfly_valid, idx_a, idx_b, bfly_stage, busy, done);
    end
    n_cmp++;
    if ({z_tw_addr, z_valid, z_idx_a, z_idx_b, z_stage, z_busy, z_done} !== '0) begin
      n_err++;
      $display("FAIL reset_state_gap0: got v=%b busy=%b done=%b expected all 0", z_valid, z_busy, z_done);
    end
    rst_n = 1'b1;
    // reset in the middle of a run
    n_acc = 0;
    bfly_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 100 && n_acc < 5; cyc++) begin
      @(negedge clk);
      if (bfly_valid && bfly_ready) n_acc++;
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tw_addr, bfly_valid, idx_a, idx_b, bfly_stage, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got tw=%0d v=%b a=%0d b=%0d s=%0d busy=%b done=%b expected all 0",
               tw_addr, bfly_valid, idx_a, idx_b, bfly_stage, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({bfly_valid, busy, done} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_after: got v=%b busy=%b done=%b expected 000", bfly_valid, busy, done);
      end
    end
  endtask

  task automatic test_abort_gap();
    int n_acc;
    n_acc = 0;
    bfly_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 100 && n_acc < HALF; cyc++) begin
      @(negedge clk);
      if (bfly_valid && bfly_ready) n_acc++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, bfly_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_in_gap: got busy=%b v=%b expected busy=1 v=0", busy, bfly_valid);
    end
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, bfly_valid, done} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b v=%b done=%b expected 000", busy, bfly_valid, done);
    end
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, bfly_valid, done} !== 3'b000) begin
        n_err++;
        $display("FAIL abort_quiet: got busy=%b v=%b done=%b expected 000", busy, bfly_valid, done);
      end
    end
    score_run("after_abort", 100, -1, -1, 1);
  endtask

  task automatic test_start_ignored();
    score_run("start_in_gap", 100, -1, 6, 1);
    score_run("start_in_run", 100, -1, 11, 0);
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, bfly_valid, done} !== 3'b000) begin
        n_err++;
        $display("FAIL start_abort_idle: got busy=%b v=%b done=%b expected 000", busy, bfly_valid, done);
      end
    end
  endtask

  task automatic test_gap0();
    int n_acc, n_done, post, first_cyc, last_cyc;
    bit done_seen;
    item_t it;
    build_exp();
    n_acc = 0; n_done = 0; post = 0; done_seen = 0; first_cyc = -1; last_cyc = -1;
    z_ready = 1'b1;
    @(posedge clk); #1 z_start = 1'b1;
    @(posedge clk); #1 z_start = 1'b0;
    for (int cyc = 0; cyc < 500 && post < 4; cyc++) begin
      @(negedge clk);
      if (z_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL gap0 extra_item: got a=%0d with none expected", z_idx_a);
        end else begin
          it = exp_q.pop_front();
          n_cmp++;
          if ({z_idx_a, z_idx_b, z_stage, z_rom_q} !== {it.a, it.b, it.s, rom[it.addr]}) begin
            n_err++;
            $display("FAIL gap0 item%0d: got a=%0d b=%0d s=%0d rom=%h expected a=%0d b=%0d s=%0d rom=%h",
                     n_acc, z_idx_a, z_idx_b, z_stage, z_rom_q, it.a, it.b, it.s, rom[it.addr]);
          end
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          n_acc++;
        end
      end
      if (z_done) begin
        n_done++;
        done_seen = 1'b1;
      end
      if (done_seen) post++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n_acc != NB || n_done != 1) begin
      n_err++;
      $display("FAIL gap0 counts: got accepts=%0d dones=%0d expected %0d and 1", n_acc, n_done, NB);
    end
    n_cmp++;
    if (last_cyc - first_cyc != NB - 1) begin
      n_err++;
      $display("FAIL gap0 back_to_back: got span %0d cycles expected %0d", last_cyc - first_cyc, NB - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bfly_ready = 1'b0;
    z_start = 1'b0; z_abort = 1'b0; z_ready = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    test_reset();
    score_run("full_run", 100, -1, -1, 1);
    score_run("stall_s1_j2", 100, 6, -1, 0);
    score_run("random_ready60", 60, -1, -1, 0);
    score_run("random_ready30", 30, -1, -1, 0);
    test_abort_gap();
    test_start_ignored();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
